// File: rtl/keypad_code_sender.sv
// Keypad front-end for the password lock: assembles a BCD code from key strobes,
// offers it over valid/ready and reports the lock's verdict as single-cycle pulses.
module keypad_code_sender #(
  parameter int NUM_DIGITS     = 4,
  parameter int TIMEOUT_CYCLES = 1000,
  localparam int CODE_W        = 4 * NUM_DIGITS,
  localparam int CNT_W         = $clog2(NUM_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_valid,
  input  logic [3:0]        key_code,
  output logic [CODE_W-1:0] code_out,
  output logic              code_valid,
  input  logic              code_ready,
  input  logic              result_valid,
  input  logic              result_access,
  output logic              busy,
  output logic [CNT_W-1:0]  digit_count,
  output logic              granted,
  output logic              denied,
  output logic              entry_error,
  output logic              timeout,
  output logic [1:0]        fsm_state
);

  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_SEND  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t               state, state_n;
  logic [TIMER_W-1:0]   timer, timer_n;
  logic [CODE_W-1:0]    code_n;
  logic [CNT_W-1:0]     count_n;
  logic                 code_valid_n, busy_n;
  logic                 granted_n, denied_n, entry_error_n, timeout_n;
  logic                 is_digit, recognised, full, expired;

  assign fsm_state = state;

  // Handshake: code is transferred on the cycle where code_valid && code_ready;
  // code_valid and code_out stay put until then.
  always_comb begin
    is_digit   = (key_code <= 4'd9);
    recognised = key_valid && (is_digit || key_code == KEY_CLEAR ||
                               key_code == KEY_BACK || key_code == KEY_ENTER);
    full       = (digit_count == CNT_W'(NUM_DIGITS));
    expired    = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    state_n       = state;
    timer_n       = timer;
    code_n        = code_out;
    count_n       = digit_count;
    code_valid_n  = code_valid;
    granted_n     = 1'b0;
    denied_n      = 1'b0;
    entry_error_n = 1'b0;
    timeout_n     = 1'b0;

    unique case (state)
      S_IDLE, S_ENTRY: begin
        if (recognised) begin
          timer_n = '0;
          if (is_digit) begin
            if (full) begin
              entry_error_n = 1'b1;
            end else begin
              code_n  = {code_out[CODE_W-5:0], key_code};
              count_n = digit_count + CNT_W'(1);
              state_n = S_ENTRY;
            end
          end else if (key_code == KEY_CLEAR) begin
            code_n  = '0;
            count_n = '0;
            state_n = S_IDLE;
          end else if (key_code == KEY_BACK) begin
            if (digit_count != '0) begin
              code_n  = code_out >> 4;
              count_n = digit_count - CNT_W'(1);
              if (digit_count == CNT_W'(1)) state_n = S_IDLE;
            end
          end else begin
            if (full) begin
              state_n      = S_SEND;
              code_valid_n = 1'b1;
            end else begin
              entry_error_n = 1'b1;
              code_n        = '0;
              count_n       = '0;
              state_n       = S_IDLE;
            end
          end
        end else if (state == S_ENTRY) begin
          // Unrecognised codes fall through here, so they never restart the timer.
          if (expired) begin
            timeout_n = 1'b1;
            code_n    = '0;
            count_n   = '0;
            timer_n   = '0;
            state_n   = S_IDLE;
          end else begin
            timer_n = timer + TIMER_W'(1);
          end
        end
      end
      S_SEND: begin
        if (code_ready) begin
          code_valid_n = 1'b0;
          timer_n      = '0;
          state_n      = S_WAIT;
        end
      end
      S_WAIT: begin
        if (result_valid) begin
          granted_n = result_access;
          denied_n  = !result_access;
          code_n    = '0;
          count_n   = '0;
          timer_n   = '0;
          state_n   = S_IDLE;
        end else if (expired) begin
          timeout_n = 1'b1;
          code_n    = '0;
          count_n   = '0;
          timer_n   = '0;
          state_n   = S_IDLE;
        end else begin
          timer_n = timer + TIMER_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase

    busy_n = (state_n == S_SEND) || (state_n == S_WAIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      code_out    <= '0;
      digit_count <= '0;
      code_valid  <= 1'b0;
      busy        <= 1'b0;
      granted     <= 1'b0;
      denied      <= 1'b0;
      entry_error <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      code_out    <= code_n;
      digit_count <= count_n;
      code_valid  <= code_valid_n;
      busy        <= busy_n;
      granted     <= granted_n;
      denied      <= denied_n;
      entry_error <= entry_error_n;
      timeout     <= timeout_n;
    end
  end

endmodule

// File: tb/tb_keypad_code_sender.sv
// Bench for keypad_code_sender: a digit-queue model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_keypad_code_sender;

  localparam int N = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic [15:0] code_out;
  logic        code_valid;
  logic        code_ready = 1'b0;
  logic        result_valid = 1'b0;
  logic        result_access = 1'b0;
  logic        busy;
  logic [2:0]  digit_count;
  logic        granted, denied, entry_error, timeout;
  logic [1:0]  fsm_state;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

  keypad_code_sender #(.NUM_DIGITS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .code_out(code_out), .code_valid(code_valid), .code_ready(code_ready),
    .result_valid(result_valid), .result_access(result_access), .busy(busy),
    .digit_count(digit_count), .granted(granted), .denied(denied),
    .entry_error(entry_error), .timeout(timeout), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // model: the entered digits as a queue plus phase flags
  logic [3:0] m_q[$];
  bit m_send = 0, m_wait = 0;
  int m_idle = 0;
  bit m_gr = 0, m_dn = 0, m_er = 0, m_to = 0;

  function automatic logic [15:0] m_code();
    logic [15:0] c = '0;
    foreach (m_q[i]) c = {c[11:0], m_q[i]};
    return c;
  endfunction

  task automatic model_step();
    bit known;
    if (reset) begin
      m_q.delete();
      m_send = 0; m_wait = 0; m_idle = 0;
      m_gr = 0; m_dn = 0; m_er = 0; m_to = 0;
      return;
    end
    m_gr = 0; m_dn = 0; m_er = 0; m_to = 0;
    if (m_send) begin
      if (code_ready) begin
        m_send = 0; m_wait = 1; m_idle = 0;
      end
    end else if (m_wait) begin
      if (result_valid) begin
        m_gr = result_access; m_dn = !result_access;
        m_q.delete(); m_wait = 0;
      end else if (m_idle == T - 1) begin
        m_to = 1; m_q.delete(); m_wait = 0;
      end else begin
        m_idle++;
      end
    end else begin
      known = key_valid && (key_code <= 4'd9 || key_code == 4'hA ||
                            key_code == 4'hB || key_code == 4'hE);
      if (known) begin
        m_idle = 0;
        if (key_code <= 4'd9) begin
          if (m_q.size() < N) m_q.push_back(key_code);
          else m_er = 1;
        end else if (key_code == 4'hA) begin
          m_q.delete();
        end else if (key_code == 4'hB) begin
          if (m_q.size() > 0) void'(m_q.pop_back());
        end else begin
          if (m_q.size() == N) m_send = 1;
          else begin
            m_er = 1; m_q.delete();
          end
        end
      end else if (m_q.size() > 0) begin
        if (m_idle == T - 1) begin
          m_to = 1; m_q.delete(); m_idle = 0;
        end else begin
          m_idle++;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // scoreboard compare on every falling edge
  initial forever begin
    @(negedge clk);
    if (!done) begin
      check("code_out", 32'(code_out), 32'(m_code()));
      check("code_valid", 32'(code_valid), 32'(m_send));
      check("busy", 32'(busy), 32'(m_send || m_wait));
      check("digit_count", 32'(digit_count), 32'(m_q.size()));
      check("granted", 32'(granted), 32'(m_gr));
      check("denied", 32'(denied), 32'(m_dn));
      check("entry_error", 32'(entry_error), 32'(m_er));
      check("timeout", 32'(timeout), 32'(m_to));
    end
  end

  // drivers
  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press(4'hE);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_code_out", 32'(code_out), 32'h0);
    check("rst_count", 32'(digit_count), 32'h0);
    check("rst_code_valid", 32'(code_valid), 32'h0);
    reset = 1'b0;

    // 1: send and grant
    code_ready = 1'b1;
    enter_code(16'h1234);
    check("t1_valid", 32'(code_valid), 32'h1);
    check("t1_code", 32'(code_out), 32'h1234);
    @(negedge clk);
    check("t1_valid_one_cycle", 32'(code_valid), 32'h0);
    check("t1_busy_wait", 32'(busy), 32'h1);
    @(negedge clk);
    result_valid = 1'b1; result_access = 1'b1;
    @(negedge clk);
    result_valid = 1'b0; result_access = 1'b0;
    check("t1_granted", 32'(granted), 32'h1);
    check("t1_count", 32'(digit_count), 32'h0);

    // 2: backspace, back-pressure, deny
    code_ready = 1'b0;
    press(4'h5); press(4'h6); press(4'hB); press(4'h7); press(4'h8); press(4'h9); press(4'hE);
    check("t2_code", 32'(code_out), 32'h5789);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t2_hold_valid", 32'(code_valid), 32'h1);
      check("t2_hold_code", 32'(code_out), 32'h5789);
    end
    code_ready = 1'b1;
    @(negedge clk);
    code_ready = 1'b0;
    check("t2_accepted", 32'(code_valid), 32'h0);
    @(negedge clk);
    result_valid = 1'b1; result_access = 1'b0;
    @(negedge clk);
    result_valid = 1'b0;
    check("t2_denied", 32'(denied), 32'h1);
    check("t2_not_granted", 32'(granted), 32'h0);

    // 3: malformed entry
    press(4'h1); press(4'h2); press(4'hE);
    check("t3_short_err", 32'(entry_error), 32'h1);
    check("t3_short_count", 32'(digit_count), 32'h0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    check("t3_over_err", 32'(entry_error), 32'h1);
    check("t3_over_code", 32'(code_out), 32'h1234);
    press(4'hA);
    check("t3_clear_count", 32'(digit_count), 32'h0);
    check("t3_clear_no_err", 32'(entry_error), 32'h0);
    press(4'hB);
    check("t3_bs_idle_no_err", 32'(entry_error), 32'h0);
    press(4'hC);
    check("t3_ignored_count", 32'(digit_count), 32'h0);

    // 4: inter-key timeout
    press(4'h3);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      check("t4_timeout_edge", 32'(timeout), 32'(j == 16));
    end
    check("t4_timeout_count", 32'(digit_count), 32'h0);
    press(4'h3);
    repeat (14) @(negedge clk);
    press(4'h4);
    check("t4_late_key_count", 32'(digit_count), 32'h2);
    check("t4_late_key_code", 32'(code_out), 32'h0034);
    press(4'hA);
    press(4'h3);
    repeat (6) @(negedge clk);
    press(4'hC);
    n = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (timeout) begin n = j; break; end
    end
    check("t4_unrecognised_no_restart", 32'(n), 32'd8);

    // 5: keys and early verdict ignored, then timeout in WAIT_RESULT
    enter_code(16'h9876);
    @(negedge clk);
    code_ready = 1'b1; result_valid = 1'b1; result_access = 1'b1;
    @(negedge clk);
    code_ready = 1'b0; result_valid = 1'b0; result_access = 1'b0;
    check("t5_verdict_in_handshake_ignored", 32'(granted), 32'h0);
    check("t5_busy", 32'(busy), 32'h1);
    press(4'h1); press(4'h2);
    check("t5_keys_ignored_count", 32'(digit_count), 32'h4);
    check("t5_keys_ignored_code", 32'(code_out), 32'h9876);
    n = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (timeout) begin n = j; break; end
    end
    check("t5_wait_timeout", 32'(n), 32'd12);
    check("t5_count_after", 32'(digit_count), 32'h0);
    check("t5_busy_after", 32'(busy), 32'h0);

    // 6: reset during SEND
    enter_code(16'h4321);
    check("t6_in_send", 32'(code_valid), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", 32'(code_valid), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_count", 32'(digit_count), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("t6_idle_valid", 32'(code_valid), 32'h0);
    press(4'h7);
    check("t6_resume_count", 32'(digit_count), 32'h1);
    check("t6_resume_code", 32'(code_out), 32'h0007);

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
